// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with one-entry skid buffer.
// The main register drives the EX-facing outputs; the skid register catches
// the one payload that can arrive while EX is stalled. This lets in_ready
// come straight from the state register, so the ready path never
// combinationally depends on out_ready.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | nothing held; out_valid=0, in_ready=1
// ST_ONE   | main holds one payload; out_valid=1, in_ready=1
// ST_FULL  | main and skid both hold payloads (main is older); in_ready=0

module id_ex_skid_reg #(
    parameter int DATA_W  = 32,
    parameter int NUM_OPS = 2,
    parameter int REG_W   = 5,
    parameter int EX_W    = 7,
    parameter int M_W     = 4,
    parameter int WB_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_OPS*DATA_W-1:0] in_ops,
    input  logic [DATA_W-1:0]         in_offset,
    input  logic [REG_W-1:0]          in_rs,
    input  logic [REG_W-1:0]          in_rt,
    input  logic [REG_W-1:0]          in_rd,
    input  logic [EX_W-1:0]           in_ctrl_ex,
    input  logic [M_W-1:0]            in_ctrl_m,
    input  logic [WB_W-1:0]           in_ctrl_wb,

    input  logic                      flush,

    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_OPS*DATA_W-1:0] out_ops,
    output logic [DATA_W-1:0]         out_offset,
    output logic [REG_W-1:0]          out_rs,
    output logic [REG_W-1:0]          out_rt,
    output logic [REG_W-1:0]          out_rd,
    output logic [EX_W-1:0]           out_ctrl_ex,
    output logic [M_W-1:0]            out_ctrl_m,
    output logic [WB_W-1:0]           out_ctrl_wb,

    output logic [CNT_W-1:0]          bubble_cnt
);

    localparam int PAY_W = NUM_OPS*DATA_W + DATA_W + 3*REG_W + EX_W + M_W + WB_W;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PAY_W-1:0]   main_q;
    logic [PAY_W-1:0]   main_d;
    logic [PAY_W-1:0]   skid_q;
    logic [PAY_W-1:0]   skid_d;
    logic [PAY_W-1:0]   in_pay;
    logic               accept;
    logic               pop;

    logic [EX_W-1:0]    main_ctrl_ex;
    logic [M_W-1:0]     main_ctrl_m;
    logic [WB_W-1:0]    main_ctrl_wb;

    // Whole payload travels as one flat vector so main/skid moves stay trivial.
    assign in_pay = {in_ops, in_offset, in_rs, in_rt, in_rd,
                     in_ctrl_ex, in_ctrl_m, in_ctrl_wb};

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Next-state and register-move decode; flush wins over any handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = in_pay;
                    end
                end
                ST_ONE: begin
                    if (accept && pop) begin
                        main_d = in_pay;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = in_pay;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and payload storage; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // Saturating count of edges that saw no valid payload toward EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

    // Data and specifiers hold their last value when idle; control groups
    // are forced to zero so an idle EX stage sees a true bubble.
    assign {out_ops, out_offset, out_rs, out_rt, out_rd,
            main_ctrl_ex, main_ctrl_m, main_ctrl_wb} = main_q;

    assign out_ctrl_ex = out_valid ? main_ctrl_ex : '0;
    assign out_ctrl_m  = out_valid ? main_ctrl_m  : '0;
    assign out_ctrl_wb = out_valid ? main_ctrl_wb : '0;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Directed and randomized checks for id_ex_skid_reg.
module tb_id_ex_skid_reg;

    localparam int PW = 124;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        flush = 1'b0;
    logic [63:0] in_ops = '0;
    logic [31:0] in_offset = '0;
    logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
    logic [6:0]  in_ctrl_ex = '0;
    logic [3:0]  in_ctrl_m = '0;
    logic [1:0]  in_ctrl_wb = '0;

    logic        in_ready, out_valid;
    logic [63:0] out_ops;
    logic [31:0] out_offset;
    logic [4:0]  out_rs, out_rt, out_rd;
    logic [6:0]  out_ctrl_ex;
    logic [3:0]  out_ctrl_m;
    logic [1:0]  out_ctrl_wb;
    logic [15:0] bubble_cnt;

    logic        in_ready4, out_valid4;
    logic [63:0] out_ops4;
    logic [31:0] out_offset4;
    logic [4:0]  out_rs4, out_rt4, out_rd4;
    logic [6:0]  out_ctrl_ex4;
    logic [3:0]  out_ctrl_m4;
    logic [1:0]  out_ctrl_wb4;
    logic [3:0]  bubble_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_skid_reg dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ops(in_ops), .in_offset(in_offset),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_ctrl_ex(in_ctrl_ex), .in_ctrl_m(in_ctrl_m), .in_ctrl_wb(in_ctrl_wb),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ops(out_ops), .out_offset(out_offset),
        .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_ctrl_ex(out_ctrl_ex), .out_ctrl_m(out_ctrl_m), .out_ctrl_wb(out_ctrl_wb),
        .bubble_cnt(bubble_cnt)
    );

    id_ex_skid_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready4),
        .in_ops(in_ops), .in_offset(in_offset),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_ctrl_ex(in_ctrl_ex), .in_ctrl_m(in_ctrl_m), .in_ctrl_wb(in_ctrl_wb),
        .flush(flush),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_ops(out_ops4), .out_offset(out_offset4),
        .out_rs(out_rs4), .out_rt(out_rt4), .out_rd(out_rd4),
        .out_ctrl_ex(out_ctrl_ex4), .out_ctrl_m(out_ctrl_m4), .out_ctrl_wb(out_ctrl_wb4),
        .bubble_cnt(bubble_cnt4)
    );

    function automatic logic [PW-1:0] mk(input logic [15:0] id);
        return {16'hA000, id, 16'hB000, id, 16'hC000, id,
                id[4:0], ~id[4:0], id[4:0] ^ 5'h15,
                {1'b1, id[5:0]}, {1'b1, id[2:0]}, {1'b1, id[0]}};
    endfunction

    function automatic logic [PW-1:0] obs();
        return {out_ops, out_offset, out_rs, out_rt, out_rd,
                out_ctrl_ex, out_ctrl_m, out_ctrl_wb};
    endfunction

    task automatic drive(input logic v, input logic [PW-1:0] p);
        in_valid = v;
        {in_ops, in_offset, in_rs, in_rt, in_rd,
         in_ctrl_ex, in_ctrl_m, in_ctrl_wb} = p;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0);
        #2;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (obs() !== '0) begin errors++; $display("FAIL reset_payload got %h want 0", obs()); end
        tick();
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL reset_bubble got %0d want 0", bubble_cnt); end
    endtask

    task automatic test_first_accept();
        drive(1'b1, {32'h2, 32'h1, 32'h0, 15'h0, 7'h11, 4'h3, 2'h1});
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_out_valid got %b want 1", out_valid); end
        checks++; if (out_ops !== {32'h2, 32'h1}) begin errors++; $display("FAIL first_out_ops got %h want 0000000200000001", out_ops); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL first_in_ready got %b want 1", in_ready); end
        checks++; if (out_ctrl_ex !== 7'h11) begin errors++; $display("FAIL first_ctrl_ex got %h want 11", out_ctrl_ex); end
        drive(1'b0, '0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_out_valid got %b want 0", out_valid); end
        checks++; if ({out_ctrl_ex, out_ctrl_m, out_ctrl_wb} !== 13'h0) begin errors++; $display("FAIL bubble_ctrl got %h want 0", {out_ctrl_ex, out_ctrl_m, out_ctrl_wb}); end
        checks++; if (out_ops !== {32'h2, 32'h1}) begin errors++; $display("FAIL bubble_ops_hold got %h want 0000000200000001", out_ops); end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] pa, pb, pc;
        pa = mk(16'h0A); pb = mk(16'h0B); pc = mk(16'h0C);
        out_ready = 1'b0;
        drive(1'b1, pa); tick();
        checks++; if (in_ready !== 1'b1 || obs() !== pa) begin errors++; $display("FAIL b2b_after_a rdy=%b out=%h want rdy=1 out=%h", in_ready, obs(), pa); end
        drive(1'b1, pb); tick();
        checks++; if (in_ready !== 1'b0 || obs() !== pa) begin errors++; $display("FAIL b2b_after_b rdy=%b out=%h want rdy=0 out=%h", in_ready, obs(), pa); end
        drive(1'b1, pc); tick();
        checks++; if (in_ready !== 1'b0 || obs() !== pa || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_c_held rdy=%b out=%h want rdy=0 out=%h", in_ready, obs(), pa); end
        out_ready = 1'b1; tick();
        checks++; if (obs() !== pb || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_second got %h rdy=%b want %h rdy=1", obs(), in_ready, pb); end
        tick();
        checks++; if (obs() !== pc || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_third got %h v=%b want %h v=1", obs(), out_valid, pc); end
        drive(1'b0, '0); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %b want 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, mk(16'h21)); tick();
        drive(1'b1, mk(16'h22)); tick();
        drive(1'b1, mk(16'h23)); flush = 1'b1; tick();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_full_valid got %b want 0", out_valid); end
        checks++; if (out_ctrl_m !== 4'h0) begin errors++; $display("FAIL flush_full_ctrl_m got %h want 0", out_ctrl_m); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_full_ready got %b want 1", in_ready); end
        drive(1'b0, '0); out_ready = 1'b1; tick(); tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_no_c got valid %b want 0", out_valid); end
        drive(1'b1, mk(16'h31)); tick();
        drive(1'b1, mk(16'h32)); flush = 1'b1; tick();
        flush = 1'b0; drive(1'b0, '0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_valid got %b want 0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_one_input_dropped got valid %b want 0", out_valid); end
    endtask

    task automatic test_async_reset();
        logic [PW-1:0] pd;
        pd = mk(16'h44);
        out_ready = 1'b0;
        drive(1'b1, mk(16'h41)); tick();
        drive(1'b1, mk(16'h42)); tick();
        drive(1'b0, '0);
        #3 rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %b want 0", out_valid); end
        checks++; if (bubble_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_bubble got %0d want 0", bubble_cnt); end
        checks++; if (in_ready !== 1'b1 || obs() !== '0) begin errors++; $display("FAIL async_rst_payload rdy=%b out=%h want rdy=1 out=0", in_ready, obs()); end
        tick();
        rst = 1'b1;
        drive(1'b1, pd); tick();
        drive(1'b0, '0);
        checks++; if (obs() !== pd || out_valid !== 1'b1 || in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_accept got %h v=%b want %h v=1", obs(), out_valid, pd); end
        out_ready = 1'b1; tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_rst_drain got %b want 0", out_valid); end
    endtask

    task automatic test_bubble_sat();
        rst = 1'b0; drive(1'b0, '0); out_ready = 1'b0;
        tick();
        rst = 1'b1;
        repeat (20) tick();
        checks++; if (bubble_cnt4 !== 4'd15) begin errors++; $display("FAIL bubble_sat4 got %0d want 15", bubble_cnt4); end
        checks++; if (bubble_cnt !== 16'd20) begin errors++; $display("FAIL bubble_cnt16 got %0d want 20", bubble_cnt); end
        repeat (3) tick();
        checks++; if (bubble_cnt4 !== 4'd15) begin errors++; $display("FAIL bubble_hold4 got %0d want 15", bubble_cnt4); end
        drive(1'b1, mk(16'h55)); tick();
        drive(1'b0, '0); tick();
        checks++; if (bubble_cnt !== 16'd24) begin errors++; $display("FAIL bubble_valid_no_inc got %0d want 24", bubble_cnt); end
    endtask

    task automatic test_random();
        logic [PW-1:0] q[$];
        logic [PW-1:0] p;
        logic [15:0]   serial;
        logic          iv, orr, fl, m_rdy, m_vld;
        serial = 16'h100;
        rst = 1'b0; tick(); rst = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            iv  = ($urandom_range(0, 3) != 0);
            orr = ($urandom_range(0, 2) != 0);
            fl  = ($urandom_range(0, 31) == 0);
            p   = mk(serial);
            drive(iv, p); out_ready = orr; flush = fl;
            m_rdy = (q.size() < 2);
            m_vld = (q.size() > 0);
            tick();
            if (fl) begin
                q.delete();
            end else begin
                if (m_vld && orr) void'(q.pop_front());
                if (iv && m_rdy) begin
                    q.push_back(p);
                    serial++;
                end
            end
            checks++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rand_state cyc=%0d v=%b rdy=%b want v=%b rdy=%b", cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++;
                if (obs() !== q[0]) begin errors++; $display("FAIL rand_order cyc=%0d got %h want %h", cyc, obs(), q[0]); end
            end else begin
                checks++;
                if ({out_ctrl_ex, out_ctrl_m, out_ctrl_wb} !== 13'h0) begin errors++; $display("FAIL rand_bubble cyc=%0d ctrl=%h want 0", cyc, {out_ctrl_ex, out_ctrl_m, out_ctrl_wb}); end
            end
        end
        flush = 1'b0; drive(1'b0, '0);
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_bubble_sat();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
